seg_capture: RTL and testbench
==============================

# seg_capture

Capture and decode block for the multiplexed seven-segment output bus (`S[2:0]` digit select, `LED[6:0]` segments) driven by the 8-bit CPU core. It sits on the same clock as the core and watches the scan.
- Each (select, pattern) pair must hold stable for a programmable number of cycles before it is accepted.
- An accepted pattern is decoded back to a hex nibble and stored per digit position.
- The block exposes the reconstructed 8-digit display to on-chip logic and self-checking benches.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical samples required before commit. Legal range 1..255.
- `clock`  in  1: rising-edge clock, shared with the CPU core.
- `nReset`  in  1: asynchronous, active-low reset.
- `S`  in  3: digit-select index, 0..7.
- `LED`  in  7: segment pattern, active-high. Bit order: `LED[0]`=a … `LED[6]`=g.
- `clr_err`  in  1: synchronous clear of `err`.
- `digits`  out  32: stored nibble for digit k at `[4k+3:4k]`.
- `valid`  out  8: bit k=1 when digit k last committed a legal hex pattern.
- `blank`  out  8: bit k=1 when digit k last committed pattern 0x00.
- `update`  out  1: one-cycle pulse when any of `digits`, `valid` or `blank` changes.
- `err`  out  1: sticky flag, set by a committed unrecognised pattern.

## Operation
- The input pair {S, LED} is sampled every edge into a 10-bit register and compared with the previous sample.
- FSM, two states:
  - TRACK: the run counter increments while the sample equals the previous sample; it resets to 1 on any difference. When the count reaches `STABLE_CYCLES`, the block commits and goes to LOCKED.
  - LOCKED: holds until the sample differs, then goes to TRACK with count 1. A pair is committed at most once per stable run.
- Decode table (gfedcba hex pattern -> value):
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
- Commit of a legal pattern to position k: `digits[k]` = value, `valid[k]`=1, `blank[k]`=0.
- Commit of 0x00: `digits[k]`=0, `valid[k]`=0, `blank[k]`=1.
- Commit of any other pattern: `digits[k]` unchanged, `valid[k]`=0, `blank[k]`=0, `err` set.
- `update` fires only if the commit changes stored state. Re-committing an identical result gives no pulse.
- `err` clears on `clr_err`. If `clr_err` and an error commit happen in the same cycle, set wins.
- `STABLE_CYCLES`=1: every changed sample commits on its first edge.

## Timing
- Reset values (async, immediate):
  - `digits`=0, `valid`=0, `blank`=0, `update`=0, `err`=0
  - state TRACK, count 0, sample register 0
- The first sample after reset always starts a new run, even if it equals 0.
- Latency:
  - Rule: a pair first sampled at edge n and held through edge n+`STABLE_CYCLES`-1 is committed at edge n+`STABLE_CYCLES`-1.
  - Outputs and `update` are registered and become visible after edge n+`STABLE_CYCLES`.
  - Example with `STABLE_CYCLES`=4: pair first sampled at edge 10, held through edge 13, outputs visible after edge 14.
- `update` is high for exactly one cycle per changing commit.
- Reset asserted mid-run: the partial run is discarded and all outputs return to reset values in the same cycle.
- Any change to `S` alone or to `LED` alone restarts the run.

## Structure
- Package `seg_capture_pkg`:
  - 7-bit segment pattern constants for 0..F and blank
  - counter width constant (8)
  - two-state FSM enum
- Sub-module `seg7_to_hex`: purely combinational. 7-bit pattern in; nibble, legal, blank out.
- The top level holds the sampler, run counter, FSM, digit register file and flags.

## Test plan
- Reset: drive any inputs during `nReset`=0 -> all outputs 0. After release with S=0, LED=00 held 4 cycles -> `blank`=01 and one `update` pulse.
- Commit: S=2, LED=5B held 4 edges -> `digits[11:8]`=2, `valid[2]`=1, single `update` pulse one cycle after the 4th edge.
- Glitch rejection: S=3, LED=4F held 3 edges, then LED=66 -> no commit of 3. After LED=66 holds 4 edges -> `digits[15:12]`=4.
- Error path:
  - S=5, LED=01 held 4 edges -> `err`=1, `valid[5]`=0, `digits[23:20]` unchanged.
  - `clr_err` pulse -> `err`=0.
  - `clr_err` asserted on the same edge as a new error commit -> `err` stays 1.
- Full scan: S=k with the pattern for k, 5 cycles each for k=0..7 -> `digits`=76543210h, `valid`=FF, 8 `update` pulses. Repeating the scan -> 0 `update` pulses.
- Reset mid-run: `nReset` pulsed low after 2 stable cycles of S=1, LED=06 -> no commit. Outputs at reset values. The run restarts after release.

Source files
------------

// File: rtl/seg_capture_pkg.sv
// Shared constants and types for the seven-segment scan capture block.
package seg_capture_pkg;

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned NDIG   = 8;
    localparam int unsigned PAIR_W = SEL_W + SEG_W;

    // gfedcba patterns, active-high
    localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_A     = 7'h77;
    localparam logic [SEG_W-1:0] SEG_B     = 7'h7C;
    localparam logic [SEG_W-1:0] SEG_C     = 7'h39;
    localparam logic [SEG_W-1:0] SEG_D     = 7'h5E;
    localparam logic [SEG_W-1:0] SEG_E     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_F     = 7'h71;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    typedef enum logic {
        ST_TRACK  = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

endpackage

// File: rtl/seg_capture_seg7_to_hex.sv
// Combinational decode of a seven-segment pattern back to a hex nibble.
module seg7_to_hex
    import seg_capture_pkg::*;
(
    input  logic [SEG_W-1:0] seg_i,
    output logic [NIB_W-1:0] nib_o,
    output logic             legal_o,
    output logic             blank_o
);

    always_comb begin
        nib_o   = '0;
        legal_o = 1'b1;
        blank_o = 1'b0;
        case (seg_i)
            SEG_0:     nib_o = 4'h0;
            SEG_1:     nib_o = 4'h1;
            SEG_2:     nib_o = 4'h2;
            SEG_3:     nib_o = 4'h3;
            SEG_4:     nib_o = 4'h4;
            SEG_5:     nib_o = 4'h5;
            SEG_6:     nib_o = 4'h6;
            SEG_7:     nib_o = 4'h7;
            SEG_8:     nib_o = 4'h8;
            SEG_9:     nib_o = 4'h9;
            SEG_A:     nib_o = 4'hA;
            SEG_B:     nib_o = 4'hB;
            SEG_C:     nib_o = 4'hC;
            SEG_D:     nib_o = 4'hD;
            SEG_E:     nib_o = 4'hE;
            SEG_F:     nib_o = 4'hF;
            SEG_BLANK: begin
                legal_o = 1'b0;
                blank_o = 1'b1;
            end
            default:   legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_capture.sv
// Debounces the multiplexed {S, LED} scan and rebuilds the 8-digit hex display.
module seg_capture
    import seg_capture_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clock,
    input  logic        nReset,
    input  logic [2:0]  S,
    input  logic [6:0]  LED,
    input  logic        clr_err,
    output logic [31:0] digits,
    output logic [7:0]  valid,
    output logic [7:0]  blank,
    output logic        update,
    output logic        err
);

    localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CYCLES);

    logic [PAIR_W-1:0] samp_q;
    logic [CNT_W-1:0]  cnt_q;
    state_e            state_q;
    logic              commit_q;

    logic [31:0]       digits_q;
    logic [NDIG-1:0]   valid_q;
    logic [NDIG-1:0]   blank_q;
    logic              update_q;
    logic              err_q;

    logic [PAIR_W-1:0] pair_c;
    logic              same_c;
    logic [CNT_W-1:0]  cnt_inc_c;

    assign pair_c    = {S, LED};
    // a zero count means no run yet, so the first post-reset sample always differs
    assign same_c    = (cnt_q != '0) && (pair_c == samp_q);
    assign cnt_inc_c = cnt_q + CNT_W'(1);

    // Sampler, run counter and TRACK/LOCKED state machine
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            samp_q   <= '0;
            cnt_q    <= '0;
            state_q  <= ST_TRACK;
            commit_q <= 1'b0;
        end else begin
            samp_q   <= pair_c;
            commit_q <= 1'b0;
            if (!same_c) begin
                cnt_q <= CNT_W'(1);
                if (STABLE_C == CNT_W'(1)) begin
                    state_q  <= ST_LOCKED;
                    commit_q <= 1'b1;
                end else begin
                    state_q  <= ST_TRACK;
                end
            end else if (state_q == ST_TRACK) begin
                cnt_q <= cnt_inc_c;
                if (cnt_inc_c == STABLE_C) begin
                    state_q  <= ST_LOCKED;
                    commit_q <= 1'b1;
                end
            end
        end
    end

    logic [SEL_W-1:0] sel_c;
    logic [4:0]       lsb_c;
    logic [NIB_W-1:0] dec_nib_c;
    logic             dec_legal_c;
    logic             dec_blank_c;
    logic [NIB_W-1:0] cur_nib_c;
    logic [NIB_W-1:0] new_nib_c;
    logic             changed_c;

    assign sel_c = samp_q[PAIR_W-1:SEG_W];
    assign lsb_c = {sel_c, 2'b00};

    seg7_to_hex u_dec (
        .seg_i   (samp_q[SEG_W-1:0]),
        .nib_o   (dec_nib_c),
        .legal_o (dec_legal_c),
        .blank_o (dec_blank_c)
    );

    // Unrecognised patterns keep the stored nibble; blank forces it to zero
    always_comb begin
        cur_nib_c = digits_q[lsb_c +: NIB_W];
        new_nib_c = cur_nib_c;
        if (dec_legal_c) begin
            new_nib_c = dec_nib_c;
        end else if (dec_blank_c) begin
            new_nib_c = '0;
        end
        changed_c = (new_nib_c != cur_nib_c)
                 || (dec_legal_c != valid_q[sel_c])
                 || (dec_blank_c != blank_q[sel_c]);
    end

    // Digit register file and status flags
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            digits_q <= '0;
            valid_q  <= '0;
            blank_q  <= '0;
            update_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            update_q <= 1'b0;
            if (commit_q) begin
                digits_q[lsb_c +: NIB_W] <= new_nib_c;
                valid_q[sel_c]           <= dec_legal_c;
                blank_q[sel_c]           <= dec_blank_c;
                update_q                 <= changed_c;
            end
            if (commit_q && !dec_legal_c && !dec_blank_c) begin
                err_q <= 1'b1;
            end else if (clr_err) begin
                err_q <= 1'b0;
            end
        end
    end

    assign digits = digits_q;
    assign valid  = valid_q;
    assign blank  = blank_q;
    assign update = update_q;
    assign err    = err_q;

endmodule

// File: tb/tb_seg_capture.sv
// Scoreboard bench for seg_capture at the default stability of 4 cycles.
module tb_seg_capture;

    logic        clock = 1'b0;
    logic        nReset;
    logic [2:0]  S;
    logic [6:0]  LED;
    logic        clr_err;
    logic [31:0] digits;
    logic [7:0]  valid;
    logic [7:0]  blank;
    logic        update;
    logic        err;

    seg_capture dut (
        .clock   (clock),
        .nReset  (nReset),
        .S       (S),
        .LED     (LED),
        .clr_err (clr_err),
        .digits  (digits),
        .valid   (valid),
        .blank   (blank),
        .update  (update),
        .err     (err)
    );

    always #5 clock = ~clock;

    localparam int K_NONE  = 0;
    localparam int K_HEX   = 1;
    localparam int K_BLANK = 2;
    localparam int K_BAD   = 3;

    int          checks   = 0;
    int          failures = 0;
    int          upd_seen = 0;
    int          base;
    logic [47:0] exp_q[$];
    logic [3:0]  m_dig[8];
    logic [7:0]  m_val;
    logic [7:0]  m_blk;
    logic [6:0]  pat[8];

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [47:0] snap();
        logic [31:0] d;
        for (int i = 0; i < 8; i++) d[i*4 +: 4] = m_dig[i];
        return {d, m_val, m_blk};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_dig[i] = 4'h0;
        m_val = 8'h00;
        m_blk = 8'h00;
        exp_q.delete();
    endtask

    // Hold a pair for n edges; push the expected display if the commit changes it
    task automatic apply(input logic [2:0] s, input logic [6:0] led, input int n,
                         input int kind, input logic [3:0] nib);
        logic [3:0] d;
        logic       v;
        logic       b;
        @(negedge clock);
        S   = s;
        LED = led;
        repeat (n) @(posedge clock);
        if (kind != K_NONE) begin
            d = m_dig[s];
            v = 1'b0;
            b = 1'b0;
            if (kind == K_HEX) begin
                d = nib;
                v = 1'b1;
            end else if (kind == K_BLANK) begin
                d = 4'h0;
                b = 1'b1;
            end
            if (d != m_dig[s] || v != m_val[s] || b != m_blk[s]) begin
                m_dig[s] = d;
                m_val[s] = v;
                m_blk[s] = b;
                exp_q.push_back(snap());
            end
        end
    endtask

    // Monitor: every update pulse must match the next expected display
    always @(negedge clock) begin
        if (nReset === 1'b1 && update === 1'b1) begin
            upd_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_update actual=%0h expected=none at %0t",
                         {digits, valid, blank}, $time);
            end else begin
                check("update_state", {digits, valid, blank}, exp_q.pop_front());
            end
        end
    end

    initial begin
        pat[0] = 7'h3F; pat[1] = 7'h06; pat[2] = 7'h5B; pat[3] = 7'h4F;
        pat[4] = 7'h66; pat[5] = 7'h6D; pat[6] = 7'h7D; pat[7] = 7'h07;
        model_reset();

        // Reset with busy inputs
        nReset  = 1'b0;
        clr_err = 1'b0;
        S       = 3'd5;
        LED     = 7'h7F;
        repeat (3) @(posedge clock);
        #1;
        check("rst_digits", 48'(digits), 48'h0);
        check("rst_valid",  48'(valid),  48'h0);
        check("rst_blank",  48'(blank),  48'h0);
        check("rst_update", 48'(update), 48'h0);
        check("rst_err",    48'(err),    48'h0);
        S   = 3'd0;
        LED = 7'h00;
        @(negedge clock) nReset = 1'b1;
        apply(3'd0, 7'h00, 4, K_BLANK, 4'h0);
        @(posedge clock);
        #1 check("post_rst_blank", 48'(blank), 48'h01);

        // Single commit with exact latency
        apply(3'd2, 7'h5B, 4, K_HEX, 4'h2);
        #1 check("latency_early", 48'(update), 48'h0);
        @(posedge clock);
        #1;
        check("latency_update", 48'(update), 48'h1);
        check("commit_digit2", 48'(digits[11:8]), 48'h2);
        check("commit_valid2", 48'(valid[2]), 48'h1);

        // Glitch rejection
        apply(3'd3, 7'h4F, 3, K_NONE, 4'h0);
        apply(3'd3, 7'h66, 4, K_HEX, 4'h4);
        @(posedge clock);
        #1 check("glitch_digit3", 48'(digits[15:12]), 48'h4);

        // Error commit leaves the digit alone
        apply(3'd5, 7'h01, 4, K_BAD, 4'h0);
        @(posedge clock);
        #1;
        check("err_set",      48'(err), 48'h1);
        check("err_valid5",   48'(valid[5]), 48'h0);
        check("err_digit5",   48'(digits[23:20]), 48'h0);
        @(negedge clock) clr_err = 1'b1;
        @(posedge clock);
        #1 check("err_cleared", 48'(err), 48'h0);
        @(negedge clock) clr_err = 1'b0;

        // Clear and new error on the same edge: set wins
        apply(3'd6, 7'h01, 4, K_BAD, 4'h0);
        @(negedge clock);
        check("err_before_collide", 48'(err), 48'h0);
        clr_err = 1'b1;
        @(posedge clock);
        #1 check("err_set_wins", 48'(err), 48'h1);
        @(negedge clock) clr_err = 1'b0;

        // Reset in the middle of a run
        apply(3'd1, 7'h06, 2, K_NONE, 4'h0);
        @(negedge clock) nReset = 1'b0;
        model_reset();
        #1;
        check("midrst_digits", 48'(digits), 48'h0);
        check("midrst_valid",  48'(valid),  48'h0);
        check("midrst_err",    48'(err),    48'h0);
        @(negedge clock) nReset = 1'b1;
        apply(3'd1, 7'h06, 4, K_HEX, 4'h1);
        repeat (2) @(posedge clock);
        #1 check("midrst_restart", 48'(digits), 48'h10);

        // Full scan from a clean state, then a repeat scan
        @(negedge clock) nReset = 1'b0;
        model_reset();
        @(negedge clock) nReset = 1'b1;
        base = upd_seen;
        for (int k = 0; k < 8; k++) apply(3'(k), pat[k], 5, K_HEX, 4'(k));
        repeat (2) @(posedge clock);
        #1;
        check("scan_updates", 48'(upd_seen - base), 48'd8);
        check("scan_digits",  48'(digits), 48'h76543210);
        check("scan_valid",   48'(valid),  48'hFF);
        base = upd_seen;
        for (int k = 0; k < 8; k++) apply(3'(k), pat[k], 5, K_HEX, 4'(k));
        repeat (2) @(posedge clock);
        #1;
        check("rescan_updates", 48'(upd_seen - base), 48'd0);
        check("queue_drained",  48'(exp_q.size()), 48'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
